ac_sensor_spi_master: RTL

SPI master for the AC controller's external temperature/humidity sensor. It sits inside the SoC, directly upstream of the sensor pad cells. It drives `spi_sensor_clk`, `spi_sensor_cs_n` and `spi_sensor_mosi`, and samples `spi_sensor_miso`. Firmware-side logic hands it fixed-width frames over a valid/ready command port and receives each response word as a one-cycle pulse. Bus format is SPI mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/ac_sensor_spi_master.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ac_sensor_spi_master.sv
// SPI mode-0 master for the AC controller's external temperature/humidity sensor.
// Fixed-width MSB-first frames; CS may be held low across frames via cmd_last_i.
module ac_sensor_spi_master #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic              cmd_last_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              spi_sensor_clk_o,
  output logic              spi_sensor_cs_n_o,
  output logic              spi_sensor_mosi_o,
  input  logic              spi_sensor_miso_i
);

  // CntW sized with CLK_DIV+1 so CLK_DIV=1 still yields a 1-bit counter.
  localparam int unsigned     CntW   = $clog2(CLK_DIV + 1);
  localparam int unsigned     BitW   = $clog2(DATA_W) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(DATA_W);

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StHold,
    StWait,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              last_q, last_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              accept;
  logic              tick;

  assign cmd_ready_o = ((state_q == StIdle) || (state_q == StWait)) && !reset_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign tick        = (cnt_q == CntMax);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    last_d      = last_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;

    if (accept) begin
      tx_d    = cmd_data_i;
      last_d  = cmd_last_i;
      rx_d    = '0;
      bit_d   = '0;
      cnt_d   = '0;
      sclk_d  = 1'b0;
      cs_n_d  = 1'b0;
      mosi_d  = cmd_data_i[DATA_W-1];
      state_d = StShift;
    end else begin
      unique case (state_q)
        StShift: begin
          if (tick) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              rx_d  = {rx_q[DATA_W-2:0], spi_sensor_miso_i};
              bit_d = bit_q + 1'b1;
            end else if (bit_q == BitMax) begin
              // Final falling edge: publish the word, MOSI keeps the LSB.
              rsp_valid_d = 1'b1;
              rsp_data_d  = rx_q;
              state_d     = last_q ? StHold : StWait;
            end else begin
              tx_d   = tx_q << 1;
              mosi_d = tx_q[DATA_W-2];
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (tick) begin
            cnt_d   = '0;
            cs_n_d  = 1'b1;
            state_d = StGap;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (tick) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      last_q      <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      last_q      <= last_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_data_o        = rsp_data_q;
  assign busy_o            = (state_q != StIdle);
  assign spi_sensor_clk_o  = sclk_q;
  assign spi_sensor_cs_n_o = cs_n_q;
  assign spi_sensor_mosi_o = mosi_q;

endmodule
